// File: rtl/pin_bus_master_if.sv
// Host-side command/response handshake of the pin-controller bus initiator.
// The host is the master of this link; pin_bus_master is the slave.
interface pin_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [20:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] cmd_repeat;
  logic [15:0] cmd_interval;
  logic        cmd_abort;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [20:0] rsp_addr;
  logic [15:0] rsp_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_repeat, cmd_interval,
           cmd_abort, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_repeat, cmd_interval,
           cmd_abort, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/pin_bus_master.sv
// Pin-controller register bus initiator: one write or (optionally repeated,
// interval-spaced) read at a time, read results returned on a valid/ready port.
module pin_bus_master #(
  parameter int unsigned READ_WAIT = 2  // data_rd cycles before capture, 1..15
) (
  input  logic             clk,
  input  logic             reset,
  pin_bus_master_if.slave  host,
  output logic [20:0]      addr,
  inout  wire  [15:0]      data,
  output logic             data_wr,
  output logic             data_rd,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_TURN, S_READ, S_RSP, S_GAP} state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT - 1);

  state_e      state_q, state_d;
  logic [20:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        data_wr_q, data_wr_d;
  logic        data_rd_q, data_rd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [20:0] rsp_addr_q, rsp_addr_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] interval_q, interval_d;
  logic [15:0] gap_q, gap_d;
  logic [3:0]  wait_q, wait_d;
  logic        abort_q, abort_d;

  // Bus is only driven during the single write cycle; reads leave it to the responder.
  assign data    = data_wr_q ? wdata_q : 16'bz;
  assign addr    = addr_q;
  assign data_wr = data_wr_q;
  assign data_rd = data_rd_q;
  assign busy    = (state_q != S_IDLE);

  assign host.cmd_ready = (state_q == S_IDLE) && !reset;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_addr  = rsp_addr_q;
  assign host.rsp_data  = rsp_data_q;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every _d takes its _q value first so no path through the case infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_wr_d   = data_wr_q;
    data_rd_d   = data_rd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    remaining_d = remaining_q;
    interval_d  = interval_q;
    gap_d       = gap_q;
    wait_d      = wait_q;
    abort_d     = abort_q;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (host.cmd_valid) begin
          addr_d      = host.cmd_addr;
          remaining_d = (host.cmd_repeat == 16'd0) ? 16'd1 : host.cmd_repeat;
          interval_d  = host.cmd_interval;
          if (host.cmd_write) begin
            wdata_d   = host.cmd_wdata;
            data_wr_d = 1'b1;
            state_d   = S_WRITE;
          end else begin
            data_rd_d = 1'b1;
            wait_d    = WAIT_LOAD;
            state_d   = S_READ;
          end
        end
      end
      S_WRITE: begin
        data_wr_d = 1'b0;
        state_d   = S_TURN;
      end
      S_TURN: state_d = S_IDLE;
      S_READ: begin
        if (host.cmd_abort) abort_d = 1'b1;
        if (wait_q == 4'd0) begin
          rsp_data_d  = data;
          rsp_addr_d  = addr_q;
          rsp_valid_d = 1'b1;
          data_rd_d   = 1'b0;
          remaining_d = remaining_q - 16'd1;
          state_d     = S_RSP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RSP: begin
        if (host.cmd_abort) abort_d = 1'b1;
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          // An abort arriving on the handshake edge itself still ends the sequence.
          if (remaining_q == 16'd0 || abort_q || host.cmd_abort) begin
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else if (interval_q == 16'd0) begin
            data_rd_d = 1'b1;
            wait_d    = WAIT_LOAD;
            state_d   = S_READ;
          end else begin
            gap_d   = interval_q - 16'd1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (host.cmd_abort) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (gap_q == 16'd0) begin
          data_rd_d = 1'b1;
          wait_d    = WAIT_LOAD;
          state_d   = S_READ;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_wr_q   <= 1'b0;
      data_rd_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      remaining_q <= '0;
      interval_q  <= '0;
      gap_q       <= '0;
      wait_q      <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_wr_q   <= data_wr_d;
      data_rd_q   <= data_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      remaining_q <= remaining_d;
      interval_q  <= interval_d;
      gap_q       <= gap_d;
      wait_q      <= wait_d;
      abort_q     <= abort_d;
    end
  end

endmodule

// File: tb/tb_pin_bus_master.sv
// Directed testbench for pin_bus_master with a simple read-responder model.
module tb_pin_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] addr;
  wire  [15:0] data;
  logic        data_wr;
  logic        data_rd;
  logic        busy;

  pin_bus_master_if hif ();

  pin_bus_master #(.READ_WAIT(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .host    (hif),
    .addr    (addr),
    .data    (data),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Responder: drives the bus only while the read strobe is up.
  logic [15:0] resp_val = 16'h0000;
  assign data = data_rd ? resp_val : 16'bz;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rises[$];
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc++;

  // Records data_rd rising edges and checks the strobes never overlap.
  always @(negedge clk) begin
    if (data_rd && !prev_rd) rises.push_back(cyc);
    prev_rd = data_rd;
    if (data_wr || data_rd) begin
      n_cmp++;
      if (data_wr && data_rd) begin
        n_bad++;
        $display("FAIL strobe_overlap: data_wr=%b data_rd=%b required not both 1", data_wr, data_rd);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer a command at a negedge and return at the negedge after it is accepted.
  task automatic issue(input logic w, input logic [20:0] a, input logic [15:0] wd,
                       input logic [15:0] rep, input logic [15:0] intv);
    int n = 0;
    hif.cmd_write    = w;
    hif.cmd_addr     = a;
    hif.cmd_wdata    = wd;
    hif.cmd_repeat   = rep;
    hif.cmd_interval = intv;
    hif.cmd_valid    = 1'b1;
    #1;
    while (!hif.cmd_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    n_cmp++;
    if (!hif.cmd_ready) begin
      n_bad++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1 within 50 cycles", hif.cmd_ready);
    end
    tick();
    hif.cmd_valid = 1'b0;
  endtask

  // Run until busy drops, counting response handshakes and checking their data.
  task automatic wait_idle(output int nrsp, input int budget);
    int n = 0;
    nrsp = 0;
    while (n < budget) begin
      if (hif.rsp_valid && hif.rsp_ready) begin
        nrsp++;
        n_cmp++;
        if (hif.rsp_data !== resp_val) begin
          n_bad++;
          $display("FAIL rsp_data_seq: got %h required %h", hif.rsp_data, resp_val);
        end
      end
      if (!busy) break;
      tick();
      n++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b required 0 within %0d cycles", busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, data_wr, data_rd, hif.rsp_valid, hif.cmd_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy/wr/rd/rsp_valid/cmd_ready=%b required 00000",
               {busy, data_wr, data_rd, hif.rsp_valid, hif.cmd_ready});
    end
    n_cmp++;
    if (addr !== 21'h0 || hif.rsp_addr !== 21'h0 || hif.rsp_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_regs: addr=%h rsp_addr=%h rsp_data=%h required 0 0 0",
               addr, hif.rsp_addr, hif.rsp_data);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (hif.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 1", hif.cmd_ready);
    end
  endtask

  task automatic test_write();
    issue(1'b1, 21'h000105, 16'h0032, 16'd0, 16'd0);
    n_cmp++;
    if (data_wr !== 1'b1 || addr !== 21'h000105 || data !== 16'h0032 || data_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL write_cycle: wr=%b rd=%b addr=%h data=%h required 1 0 000105 0032",
               data_wr, data_rd, addr, data);
    end
    n_cmp++;
    if (hif.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL write_ready1: cmd_ready=%b required 0", hif.cmd_ready);
    end
    tick();
    n_cmp++;
    if (data_wr !== 1'b0 || addr !== 21'h000105 || hif.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL write_turn: wr=%b addr=%h cmd_ready=%b busy=%b required 0 000105 0 1",
               data_wr, addr, hif.cmd_ready, busy);
    end
    tick();
    n_cmp++;
    if (hif.cmd_ready !== 1'b1 || busy !== 1'b0 || hif.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL write_done: cmd_ready=%b busy=%b rsp_valid=%b required 1 0 0",
               hif.cmd_ready, busy, hif.rsp_valid);
    end
  endtask

  task automatic test_read_single();
    resp_val = 16'h0001;
    hif.rsp_ready = 1'b0;
    issue(1'b0, 21'h000207, 16'hFFFF, 16'd1, 16'd0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (data_rd !== 1'b1 || data_wr !== 1'b0 || hif.rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL read_strobe%0d: rd=%b wr=%b rsp_valid=%b required 1 0 0",
                 i, data_rd, data_wr, hif.rsp_valid);
      end
      tick();
    end
    n_cmp++;
    if (data_rd !== 1'b0 || hif.rsp_valid !== 1'b1 || hif.rsp_data !== 16'h0001 ||
        hif.rsp_addr !== 21'h000207) begin
      n_bad++;
      $display("FAIL read_rsp: rd=%b valid=%b data=%h addr=%h required 0 1 0001 000207",
               data_rd, hif.rsp_valid, hif.rsp_data, hif.rsp_addr);
    end
    hif.rsp_ready = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (hif.rsp_valid !== 1'b0 || hif.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL read_handshake: rsp_valid=%b cmd_ready=%b required 0 1",
               hif.rsp_valid, hif.cmd_ready);
    end
    hif.rsp_ready = 1'b0;
  endtask

  task automatic test_repeat();
    int nrsp;
    resp_val = 16'hA5C3;
    hif.rsp_ready = 1'b1;
    rises.delete();
    issue(1'b0, 21'h000311, 16'h0, 16'd4, 16'd10);
    wait_idle(nrsp, 200);
    n_cmp++;
    if (nrsp != 4 || rises.size() != 4) begin
      n_bad++;
      $display("FAIL repeat_count: responses=%0d reads=%0d required 4 4", nrsp, rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      n_cmp++;
      if (rises[i] - rises[i-1] != 13) begin
        n_bad++;
        $display("FAIL repeat_spacing%0d: got %0d cycles required 13", i, rises[i] - rises[i-1]);
      end
    end
    hif.rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    int nrsp;
    int n = 0;
    resp_val = 16'h1111;
    hif.rsp_ready = 1'b0;
    rises.delete();
    issue(1'b0, 21'h000400, 16'h0, 16'd3, 16'd2);
    while (!hif.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    resp_val = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (hif.rsp_valid !== 1'b1 || hif.rsp_data !== 16'h1111 || data_rd !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: valid=%b data=%h rd=%b required 1 1111 0",
                 i, hif.rsp_valid, hif.rsp_data, data_rd);
      end
      tick();
    end
    n_cmp++;
    if (rises.size() != 1) begin
      n_bad++;
      $display("FAIL stall_no_read: reads=%0d required 1", rises.size());
    end
    resp_val = 16'h1111;
    hif.rsp_ready = 1'b1;
    wait_idle(nrsp, 200);
    n_cmp++;
    if (nrsp != 3 || rises.size() != 3) begin
      n_bad++;
      $display("FAIL stall_total: responses=%0d reads=%0d required 3 3", nrsp, rises.size());
    end
    hif.rsp_ready = 1'b0;
  endtask

  task automatic test_repeat_zero();
    int nrsp;
    resp_val = 16'h0BAD;
    hif.rsp_ready = 1'b1;
    rises.delete();
    issue(1'b0, 21'h000500, 16'h0, 16'd0, 16'd3);
    wait_idle(nrsp, 100);
    n_cmp++;
    if (nrsp != 1 || rises.size() != 1) begin
      n_bad++;
      $display("FAIL repeat_zero: responses=%0d reads=%0d required 1 1", nrsp, rises.size());
    end
    hif.rsp_ready = 1'b0;
  endtask

  task automatic test_abort_gap();
    int n = 0;
    resp_val = 16'h7E57;
    hif.rsp_ready = 1'b1;
    rises.delete();
    issue(1'b0, 21'h000600, 16'h0, 16'd5, 16'd10);
    while (!hif.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    // Handshake on the next edge moves into the 10-cycle gap; abort a few cycles in.
    tick();
    tick();
    tick();
    hif.cmd_abort = 1'b1;
    tick();
    hif.cmd_abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hif.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b cmd_ready=%b required 0 1", busy, hif.cmd_ready);
    end
    repeat (30) tick();
    n_cmp++;
    if (rises.size() != 1 || hif.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_read: reads=%0d rsp_valid=%b required 1 0",
               rises.size(), hif.rsp_valid);
    end
    hif.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    resp_val = 16'h3C3C;
    hif.rsp_ready = 1'b0;
    issue(1'b0, 21'h000700, 16'h0, 16'd2, 16'd0);
    n_cmp++;
    if (data_rd !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pre: data_rd=%b required 1", data_rd);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (data_rd !== 1'b0 || data_wr !== 1'b0 || hif.rsp_valid !== 1'b0 || busy !== 1'b0 ||
        hif.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_state: rd=%b wr=%b valid=%b busy=%b ready=%b required 0 0 0 0 0",
               data_rd, data_wr, hif.rsp_valid, busy, hif.cmd_ready);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (hif.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_ready: cmd_ready=%b required 1", hif.cmd_ready);
    end
    repeat (5) tick();
    n_cmp++;
    if (hif.rsp_valid !== 1'b0 || data_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_dropped: rsp_valid=%b data_rd=%b required 0 0",
               hif.rsp_valid, data_rd);
    end
  endtask

  initial begin
    hif.cmd_valid    = 1'b0;
    hif.cmd_write    = 1'b0;
    hif.cmd_addr     = '0;
    hif.cmd_wdata    = '0;
    hif.cmd_repeat   = '0;
    hif.cmd_interval = '0;
    hif.cmd_abort    = 1'b0;
    hif.rsp_ready    = 1'b0;
    test_reset();
    test_write();
    test_read_single();
    test_repeat();
    test_stall();
    test_repeat_zero();
    test_abort_gap();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
